// File: rtl/purse_controller_if.sv
// Handshake and HUD bus between the deploy/upgrade UI, battle engine and purse controller.
interface purse_controller_if #(
    parameter int MONEY_W = 14
);
    logic               start;
    logic               game_en;
    logic               tick;
    logic               reward_vld;
    logic [MONEY_W-1:0] reward;
    logic               spawn_req;
    logic [MONEY_W-1:0] spawn_cost;
    logic               upg_req;
    logic               spawn_ack;
    logic               spawn_nak;
    logic               upg_ack;
    logic               upg_nak;
    logic [MONEY_W-1:0] money;
    logic [2:0]         level;
    logic [MONEY_W-1:0] max_money;
    logic [MONEY_W-1:0] upg_cost;

    modport master (
        output start, game_en, tick, reward_vld, reward, spawn_req, spawn_cost, upg_req,
        input  spawn_ack, spawn_nak, upg_ack, upg_nak, money, level, max_money, upg_cost
    );

    modport slave (
        input  start, game_en, tick, reward_vld, reward, spawn_req, spawn_cost, upg_req,
        output spawn_ack, spawn_nak, upg_ack, upg_nak, money, level, max_money, upg_cost
    );
endinterface

// File: rtl/purse_controller.sv
// Battle purse: tick income, kill rewards, round-robin spawn/upgrade arbitration on one money register.
// Requests decided in IDLE, ack/nak and debit visible one edge later; requesters hold req until ack/nak.
module purse_controller #(
    parameter int RATE_BASE = 4,
    parameter int RATE_STEP = 2,
    parameter int MONEY_W   = 14
) (
    input  logic              clk,
    input  logic              rst,
    purse_controller_if.slave bus
);
    typedef enum logic {IDLE, RESP} state_t;
    typedef enum logic {SEL_SPAWN, SEL_UPG} sel_t;

    state_t             state_q, state_d;
    sel_t               rr_q, rr_d, sel;
    logic [MONEY_W-1:0] money_q, money_d, debit, cap_d;
    logic [2:0]         level_q, level_d;
    logic               spawn_ack_q, spawn_nak_q, upg_ack_q, upg_nak_q;
    logic               spawn_ack_d, spawn_nak_d, upg_ack_d, upg_nak_d;
    logic [15:0]        rate, total;

    function automatic logic [MONEY_W-1:0] cap_of(input logic [2:0] l);
        case (l)
            3'd0:    cap_of = MONEY_W'(100);
            3'd1:    cap_of = MONEY_W'(300);
            3'd2:    cap_of = MONEY_W'(500);
            3'd3:    cap_of = MONEY_W'(1000);
            3'd4:    cap_of = MONEY_W'(2000);
            3'd5:    cap_of = MONEY_W'(4000);
            3'd6:    cap_of = MONEY_W'(6000);
            default: cap_of = MONEY_W'(10000);
        endcase
    endfunction

    function automatic logic [MONEY_W-1:0] cost_of(input logic [2:0] l);
        case (l)
            3'd0:    cost_of = MONEY_W'(100);
            3'd1:    cost_of = MONEY_W'(200);
            3'd2:    cost_of = MONEY_W'(400);
            3'd3:    cost_of = MONEY_W'(600);
            3'd4:    cost_of = MONEY_W'(1000);
            3'd5:    cost_of = MONEY_W'(2000);
            3'd6:    cost_of = MONEY_W'(4000);
            default: cost_of = MONEY_W'(8000);
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= SEL_SPAWN;
            money_q     <= '0;
            level_q     <= '0;
            spawn_ack_q <= 1'b0;
            spawn_nak_q <= 1'b0;
            upg_ack_q   <= 1'b0;
            upg_nak_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            money_q     <= money_d;
            level_q     <= level_d;
            spawn_ack_q <= spawn_ack_d;
            spawn_nak_q <= spawn_nak_d;
            upg_ack_q   <= upg_ack_d;
            upg_nak_q   <= upg_nak_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        sel         = rr_q;
        level_d     = level_q;
        debit       = '0;
        spawn_ack_d = 1'b0;
        spawn_nak_d = 1'b0;
        upg_ack_d   = 1'b0;
        upg_nak_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.spawn_req || bus.upg_req) begin
                    if (bus.spawn_req && bus.upg_req) sel = rr_q;
                    else if (bus.spawn_req)           sel = SEL_SPAWN;
                    else                              sel = SEL_UPG;
                    rr_d    = (sel == SEL_SPAWN) ? SEL_UPG : SEL_SPAWN;
                    state_d = RESP;
                    // Affordability uses money before this cycle's income/reward.
                    if (sel == SEL_SPAWN) begin
                        if (bus.game_en && money_q >= bus.spawn_cost) begin
                            spawn_ack_d = 1'b1;
                            debit       = bus.spawn_cost;
                        end else begin
                            spawn_nak_d = 1'b1;
                        end
                    end else begin
                        if (bus.game_en && level_q != 3'd7 && money_q >= cost_of(level_q)) begin
                            upg_ack_d = 1'b1;
                            debit     = cost_of(level_q);
                            level_d   = level_q + 3'd1;
                        end else begin
                            upg_nak_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rate    = 16'(RATE_BASE) + 16'(level_q) * 16'(RATE_STEP);
        total   = 16'(money_q) - 16'(debit)
                + ((bus.tick && bus.game_en) ? rate : 16'd0)
                + (bus.reward_vld ? 16'(bus.reward) : 16'd0);
        cap_d   = cap_of(level_d);
        money_d = (total > 16'(cap_d)) ? cap_d : total[MONEY_W-1:0];

        if (bus.start) begin
            state_d     = IDLE;
            rr_d        = SEL_SPAWN;
            money_d     = '0;
            level_d     = '0;
            spawn_ack_d = 1'b0;
            spawn_nak_d = 1'b0;
            upg_ack_d   = 1'b0;
            upg_nak_d   = 1'b0;
        end
    end

    assign bus.spawn_ack = spawn_ack_q;
    assign bus.spawn_nak = spawn_nak_q;
    assign bus.upg_ack   = upg_ack_q;
    assign bus.upg_nak   = upg_nak_q;
    assign bus.money     = money_q;
    assign bus.level     = level_q;
    assign bus.max_money = cap_of(level_q);
    assign bus.upg_cost  = cost_of(level_q);
endmodule

// File: tb/tb_purse_controller.sv
// Scoreboarded bench for purse_controller: responses are matched against expectations queued at request time.
module tb_purse_controller;
    typedef struct {
        logic [3:0]  resp;   // {spawn_ack, spawn_nak, upg_ack, upg_nak}
        logic [13:0] money;
        logic [2:0]  level;
    } exp_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   resp_seen;
    int   cyc;
    exp_t q[$];
    exp_t mon_e;
    logic [3:0] mon_r;

    int cap_t[8]  = '{100, 300, 500, 1000, 2000, 4000, 6000, 10000};
    int cost_t[8] = '{100, 200, 400, 600, 1000, 2000, 4000, 8000};

    purse_controller_if #(.MONEY_W(14)) bus ();

    purse_controller #(.RATE_BASE(4), .RATE_STEP(2), .MONEY_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            mon_r = {bus.spawn_ack, bus.spawn_nak, bus.upg_ack, bus.upg_nak};
            if (mon_r != 4'b0000) begin
                resp_seen++;
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_resp: got resp=%b money=%0d level=%0d, none expected",
                             mon_r, bus.money, bus.level);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_r !== mon_e.resp || bus.money !== mon_e.money || bus.level !== mon_e.level) begin
                        tests_failed++;
                        $display("FAIL resp_check: got resp=%b money=%0d level=%0d, expected resp=%b money=%0d level=%0d",
                                 mon_r, bus.money, bus.level, mon_e.resp, mon_e.money, mon_e.level);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic give_reward(input int amt);
        bus.reward_vld = 1'b1;
        bus.reward     = 14'(amt);
        step();
        bus.reward_vld = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] r, input int m, input int l);
        exp_t e;
        e.resp  = r;
        e.money = 14'(m);
        e.level = 3'(l);
        q.push_back(e);
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 20; i++) begin
            if (resp_seen >= target) break;
            @(negedge clk);
            #1;
        end
        tests_run++;
        if (resp_seen < target) begin
            tests_failed++;
            $display("FAIL resp_timeout: seen %0d responses, required %0d", resp_seen, target);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({bus.spawn_ack, bus.spawn_nak, bus.upg_ack, bus.upg_nak} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_acks: got %b, expected 0000", {bus.spawn_ack, bus.spawn_nak, bus.upg_ack, bus.upg_nak});
        end
        tests_run++;
        if (bus.money !== 14'd0 || bus.level !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_money_level: got money=%0d level=%0d, expected 0/0", bus.money, bus.level);
        end
        tests_run++;
        if (bus.max_money !== 14'd100 || bus.upg_cost !== 14'd100) begin
            tests_failed++;
            $display("FAIL reset_tables: got max=%0d cost=%0d, expected 100/100", bus.max_money, bus.upg_cost);
        end
    endtask

    task automatic test_income();
        int exp_m;
        bus.game_en = 1'b1;
        do_start();
        bus.tick = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            exp_m = (4 * k > 100) ? 100 : 4 * k;
            tests_run++;
            if (bus.money !== 14'(exp_m)) begin
                tests_failed++;
                $display("FAIL income_k%0d: got money=%0d, expected %0d", k, bus.money, exp_m);
            end
        end
        bus.tick = 1'b0;
    endtask

    task automatic test_upgrade();
        int n0 = resp_seen;
        push_exp(4'b0010, 0, 1);
        bus.upg_req = 1'b1;
        wait_resp(n0 + 1);
        step();
        bus.upg_req = 1'b0;
        tests_run++;
        if (bus.max_money !== 14'd300 || bus.upg_cost !== 14'd200) begin
            tests_failed++;
            $display("FAIL upgrade_tables: got max=%0d cost=%0d, expected 300/200", bus.max_money, bus.upg_cost);
        end
    endtask

    task automatic test_spawn();
        int n0;
        give_reward(120);
        tests_run++;
        if (bus.money !== 14'd120) begin
            tests_failed++;
            $display("FAIL spawn_setup: got money=%0d, expected 120", bus.money);
        end
        n0 = resp_seen;
        push_exp(4'b0100, 120, 1);
        bus.spawn_cost = 14'd150;
        bus.spawn_req  = 1'b1;
        wait_resp(n0 + 1);
        step();
        bus.spawn_req = 1'b0;
        push_exp(4'b1000, 20, 1);
        bus.spawn_cost = 14'd100;
        bus.spawn_req  = 1'b1;
        wait_resp(n0 + 2);
        step();
        bus.spawn_req = 1'b0;
    endtask

    task automatic test_pause();
        int n0 = resp_seen;
        push_exp(4'b0100, 50, 1);
        bus.game_en    = 1'b0;
        bus.tick       = 1'b1;
        bus.reward_vld = 1'b1;
        bus.reward     = 14'd30;
        bus.spawn_cost = 14'd10;
        bus.spawn_req  = 1'b1;
        step();
        bus.reward_vld = 1'b0;
        wait_resp(n0 + 1);
        step();
        bus.spawn_req = 1'b0;
        tests_run++;
        if (bus.money !== 14'd50) begin
            tests_failed++;
            $display("FAIL pause_no_income: got money=%0d, expected 50", bus.money);
        end
        bus.tick    = 1'b0;
        bus.game_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int n0, c1, c2;
        do_start();
        give_reward(100);
        n0 = resp_seen;
        push_exp(4'b1000, 100, 0);
        push_exp(4'b0010, 100, 1);
        bus.reward_vld = 1'b1;
        bus.reward     = 14'd100;
        bus.spawn_cost = 14'd30;
        bus.spawn_req  = 1'b1;
        bus.upg_req    = 1'b1;
        wait_resp(n0 + 1);
        c1 = cyc;
        step();
        bus.spawn_req = 1'b0;
        wait_resp(n0 + 2);
        c2 = cyc;
        step();
        bus.upg_req    = 1'b0;
        bus.reward_vld = 1'b0;
        tests_run++;
        if (c2 - c1 !== 2) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d cycles between acks, expected 2", c2 - c1);
        end
    endtask

    task automatic test_max_level();
        int n0;
        do_start();
        for (int l = 0; l < 7; l++) begin
            give_reward(16383);
            tests_run++;
            if (bus.money !== 14'(cap_t[l])) begin
                tests_failed++;
                $display("FAIL cap_level%0d: got money=%0d, expected %0d", l, bus.money, cap_t[l]);
            end
            n0 = resp_seen;
            push_exp(4'b0010, cap_t[l] - cost_t[l], l + 1);
            bus.upg_req = 1'b1;
            wait_resp(n0 + 1);
            step();
            bus.upg_req = 1'b0;
        end
        give_reward(16383);
        n0 = resp_seen;
        push_exp(4'b0001, 10000, 7);
        bus.upg_req = 1'b1;
        wait_resp(n0 + 1);
        step();
        bus.upg_req = 1'b0;
        push_exp(4'b1000, 9800, 7);
        bus.spawn_cost = 14'd200;
        bus.spawn_req  = 1'b1;
        wait_resp(n0 + 2);
        step();
        bus.spawn_req = 1'b0;
        give_reward(500);
        tests_run++;
        if (bus.money !== 14'd10000 || bus.level !== 3'd7) begin
            tests_failed++;
            $display("FAIL max_saturate: got money=%0d level=%0d, expected 10000/7", bus.money, bus.level);
        end
    endtask

    task automatic test_reset_mid_resp();
        int n0;
        do_start();
        give_reward(100);
        bus.spawn_cost = 14'd40;
        bus.spawn_req  = 1'b1;
        step();
        tests_run++;
        if (bus.spawn_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_rst_ack: got spawn_ack=%b, expected 1", bus.spawn_ack);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.spawn_ack, bus.spawn_nak, bus.upg_ack, bus.upg_nak} !== 4'b0000
            || bus.money !== 14'd0 || bus.level !== 3'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_resp: got resp=%b money=%0d level=%0d, expected 0000/0/0",
                     {bus.spawn_ack, bus.spawn_nak, bus.upg_ack, bus.upg_nak}, bus.money, bus.level);
        end
        bus.spawn_req = 1'b0;
        #4 rst = 1'b0;
        step();
        give_reward(100);
        n0 = resp_seen;
        bus.start     = 1'b1;
        bus.spawn_req = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.spawn_req = 1'b0;
        tests_run++;
        if (bus.spawn_ack !== 1'b0 || bus.money !== 14'd0) begin
            tests_failed++;
            $display("FAIL start_in_flight: got spawn_ack=%b money=%0d, expected 0/0", bus.spawn_ack, bus.money);
        end
        step();
        tests_run++;
        if (resp_seen !== n0) begin
            tests_failed++;
            $display("FAIL start_dropped: got %0d responses, expected %0d", resp_seen, n0);
        end
        give_reward(50);
        push_exp(4'b1000, 10, 0);
        bus.spawn_req = 1'b1;
        wait_resp(n0 + 1);
        step();
        bus.spawn_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        resp_seen      = 0;
        cyc            = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.game_en    = 1'b0;
        bus.tick       = 1'b0;
        bus.reward_vld = 1'b0;
        bus.reward     = '0;
        bus.spawn_req  = 1'b0;
        bus.spawn_cost = '0;
        bus.upg_req    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        test_reset();
        rst = 1'b0;
        step();
        test_income();
        test_upgrade();
        test_spawn();
        test_pause();
        test_back_to_back();
        test_max_level();
        test_reset_mid_resp();
        repeat (3) step();
        tests_run++;
        if (q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d expected responses never seen, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
